multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum request cycles without ack before a fault; 0 disables timeout.
REQ-002 Parameter CNT_W, default 5: timeout counter width, SHALL satisfy 2^CNT_W > MEM_TIMEOUT.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  32  instruction register contents, valid from DECODE onward.
REQ-006 imem_ack  input  1  instruction memory ack; instr is loaded on the same edge via ir_we.
REQ-007 dmem_ack  input  1  data memory ack.
REQ-008 branch_taken  input  1  ALU compare result, sampled in EXEC.
REQ-009 imem_req, dmem_req, dmem_we  output  1 each  memory request strobes.
REQ-010 ir_we, pc_we, pc_sel, reg_we, alu_src, mem_to_reg, retire  output  1 each  datapath controls; pc_sel 0=pc+4, 1=target.
REQ-011 alu_ctrl  output  4  {funct7[5]-qualified bit, funct3}.
REQ-012 state  output  3  current FSM state; fault  output  1; fault_cause  output  2.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; codes 6-7 SHALL go to FAULT with cause 11.
REQ-014 FETCH: imem_req=1; on imem_ack, ir_we=1 for that cycle and go to DECODE.
REQ-015 DECODE: opcode 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 SHALL go to EXEC; any other opcode SHALL go to FAULT with cause 11.
REQ-016 EXEC R-type/I-ALU: alu_src=0 (R) or 1 (I); go to WB.
REQ-017 EXEC load/store: alu_src=1, alu_ctrl=0000; go to MEM.
REQ-018 EXEC branch: alu_ctrl=1000, pc_we=1, pc_sel=branch_taken, retire=1; go to FETCH.
REQ-019 EXEC JAL: pc_sel=1 recorded for WB; go to WB.
REQ-020 MEM: dmem_req=1, dmem_we=1 for store only; on dmem_ack, a load SHALL go to WB, while a store SHALL assert pc_we=1, pc_sel=0, retire=1 and go to FETCH.
REQ-021 WB: reg_we=1, mem_to_reg=1 for load only, pc_we=1, pc_sel=1 for JAL else 0, retire=1; go to FETCH.
REQ-022 alu_ctrl: R-type {funct7[5],funct3}; I-ALU {funct7[5]&(funct3==101),funct3}; load/store/JAL 0000; branch 1000.
REQ-023 All strobes are Moore outputs of the current state and decoded opcode; no strobe SHALL assert outside its stated state.
REQ-024 Timeout counter: cleared on entry to FETCH/MEM; increments each cycle with req=1 and ack=0.
REQ-025 When the counter reaches MEM_TIMEOUT-1 and ack=0, the FSM SHALL go to FAULT; cause 01 (imem) or 10 (dmem).
REQ-026 An ack arriving in the same cycle as the timeout threshold SHALL win; no fault.
REQ-027 MEM_TIMEOUT=0: counter disabled; wait indefinitely.
REQ-028 FAULT: sticky until reset; fault=1, all strobes 0, fault_cause held.
REQ-029 retire SHALL pulse exactly once per completed instruction; instruction latency SHALL be 3 cycles for branch, 4 for R/I/JAL and store, 5 for load, plus memory wait cycles.

Reset
REQ-030 reset=1 on an edge SHALL force state=FETCH, counter=0, fault=0, fault_cause=00, and all strobes 0 in the following cycle.
REQ-031 Reset SHALL take priority over every transition, including mid-MEM and FAULT.
REQ-032 After reset release, imem_req SHALL assert in the first cycle.

Verification
REQ-033 add x1,x2,x3 (0x003100B3), imem_ack immediate -> state sequence 0,1,2,4,0; alu_ctrl=0000 in EXEC; reg_we, pc_we and retire high in WB only.
REQ-034 lw (opcode 0000011), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with mem_to_reg=1; retire once.
REQ-035 beq with branch_taken=1 -> in EXEC, pc_we=1, pc_sel=1, alu_ctrl=1000, retire=1; next state FETCH.
REQ-036 imem_ack held 0 with MEM_TIMEOUT=16 -> FAULT after 16 request cycles, fault_cause=01; ack on the 16th cycle -> no fault.
REQ-037 instr=0xFFFFFFFF -> DECODE then FAULT, cause 11; reset pulse -> FETCH, fault=0.
REQ-038 sw (opcode 0100011) with reset asserted during MEM -> dmem_req=0 next cycle, state=FETCH, no retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory-ack timeout supervision and a sticky fault state.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        retire,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
    } op_t;

    state_t           cur;
    op_t              op_class;
    logic [CNT_W-1:0] wait_cnt;

    op_t  dec_class;
    logic dec_valid;
    logic timeout_hit;
    logic [2:0] funct3;
    logic unused_instr_bits;

    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign state             = cur;

    // The threshold is only meaningful when a nonzero timeout is configured.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        dec_valid = 1'b1;
        dec_class = OP_R;
        case (instr[6:0])
            7'b0110011: dec_class = OP_R;
            7'b0010011: dec_class = OP_I;
            7'b0000011: dec_class = OP_LOAD;
            7'b0100011: dec_class = OP_STORE;
            7'b1100011: dec_class = OP_BRANCH;
            7'b1101111: dec_class = OP_JAL;
            default:    dec_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            op_class    <= OP_R;
            wait_cnt    <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (imem_ack) begin
                        cur <= S_DECODE;
                    end else if (timeout_hit) begin
                        cur         <= S_FAULT;
                        fault       <= 1'b1;
                        fault_cause <= 2'b01;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_valid) begin
                        op_class <= dec_class;
                        cur      <= S_EXEC;
                    end else begin
                        cur         <= S_FAULT;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    case (op_class)
                        OP_LOAD, OP_STORE: cur <= S_MEM;
                        OP_BRANCH:         cur <= S_FETCH;
                        default:           cur <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt <= '0;
                        cur      <= (op_class == OP_LOAD) ? S_WB : S_FETCH;
                    end else if (timeout_hit) begin
                        cur         <= S_FAULT;
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    cur      <= S_FETCH;
                end
                S_FAULT: cur <= S_FAULT;
                default: begin
                    cur         <= S_FAULT;
                    fault       <= 1'b1;
                    fault_cause <= 2'b11;
                end
            endcase
        end
    end

    // Strobes follow the current state and latched opcode class; nothing is issued while reset is held.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        reg_we     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        alu_ctrl   = 4'b0000;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    case (op_class)
                        OP_R: alu_ctrl = {instr[30], funct3};
                        OP_I: begin
                            alu_src  = 1'b1;
                            alu_ctrl = {instr[30] & (funct3 == 3'b101), funct3};
                        end
                        OP_LOAD, OP_STORE: alu_src = 1'b1;
                        OP_BRANCH: begin
                            alu_ctrl = 4'b1000;
                            pc_we    = 1'b1;
                            pc_sel   = branch_taken;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_class == OP_STORE);
                    if (dmem_ack && op_class == OP_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = (op_class == OP_LOAD);
                    pc_we      = 1'b1;
                    pc_sel     = (op_class == OP_JAL);
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance with the default timeout and one
// with the timeout disabled, both driven by the same stimulus.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h40310133;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_ADDI = 32'h40000093;
    localparam logic [31:0] I_LW   = 32'h00012083;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset, imem_ack, dmem_ack, branch_taken;
    logic [31:0] instr;

    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_src, mem_to_reg, retire;
    logic [3:0] alu_ctrl;
    logic [2:0] state;
    logic fault;
    logic [1:0] fault_cause;

    logic nt_imem_req, nt_dmem_req, nt_dmem_we, nt_ir_we, nt_pc_we, nt_pc_sel, nt_reg_we;
    logic nt_alu_src, nt_mem_to_reg, nt_retire, nt_fault;
    logic [3:0] nt_alu_ctrl;
    logic [2:0] nt_state;
    logic [1:0] nt_fault_cause;

    int checks = 0;
    int passes = 0;
    int retire_cnt = 0;
    int dreq_cnt = 0;
    int r0, d0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .retire(retire), .alu_ctrl(alu_ctrl), .state(state),
        .fault(fault), .fault_cause(fault_cause)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(5)) dut_nt (
        .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .imem_req(nt_imem_req), .dmem_req(nt_dmem_req),
        .dmem_we(nt_dmem_we), .ir_we(nt_ir_we), .pc_we(nt_pc_we), .pc_sel(nt_pc_sel),
        .reg_we(nt_reg_we), .alu_src(nt_alu_src), .mem_to_reg(nt_mem_to_reg), .retire(nt_retire),
        .alu_ctrl(nt_alu_ctrl), .state(nt_state), .fault(nt_fault), .fault_cause(nt_fault_cause)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (retire) retire_cnt++;
        if (dmem_req) dreq_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] i, input logic ia,
                                 input logic da, input logic bt);
        reset = r;
        instr = i;
        imem_ack = ia;
        dmem_ack = da;
        branch_taken = bt;
        #1;
    endtask

    // From FETCH: fetch with immediate ack, pass DECODE, end in the cycle after DECODE.
    task automatic fetchDecode(input logic [31:0] w, input logic bt);
        applyStimulus(1'b0, w, 1'b1, 1'b0, bt);
        cyc();
        applyStimulus(1'b0, w, 1'b0, 1'b0, bt);
        cyc();
    endtask

    initial begin
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_cause", 32'(fault_cause), 32'd0);
        checkOutput("rst_imem_req_held", 32'(imem_req), 32'd0);

        // add: 0,1,2,4,0
        r0 = retire_cnt;
        applyStimulus(1'b0, I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("add_first_imem_req", 32'(imem_req), 32'd1);
        checkOutput("add_ir_we", 32'(ir_we), 32'd1);
        cyc();
        applyStimulus(1'b0, I_ADD, 1'b0, 1'b0, 1'b0);
        checkOutput("add_decode", 32'(state), 32'd1);
        checkOutput("add_decode_imem_req", 32'(imem_req), 32'd0);
        cyc();
        checkOutput("add_exec", 32'(state), 32'd2);
        checkOutput("add_alu_ctrl", 32'(alu_ctrl), 32'h0);
        checkOutput("add_exec_regwe_pcwe_ret", 32'({reg_we, pc_we, retire}), 32'b000);
        cyc();
        checkOutput("add_wb", 32'(state), 32'd4);
        checkOutput("add_wb_regwe_pcwe_ret", 32'({reg_we, pc_we, retire, pc_sel, mem_to_reg}), 32'b11100);
        cyc();
        checkOutput("add_back_fetch", 32'(state), 32'd0);
        checkOutput("add_retire_once", 32'(retire_cnt - r0), 32'd1);

        fetchDecode(I_SUB, 1'b0);
        checkOutput("sub_alu", 32'({alu_src, alu_ctrl}), 32'b0_1000);
        cyc(); cyc();
        fetchDecode(I_SRAI, 1'b0);
        checkOutput("srai_alu", 32'({alu_src, alu_ctrl}), 32'b1_1101);
        cyc(); cyc();
        fetchDecode(I_ADDI, 1'b0);
        checkOutput("addi_alu_bit30", 32'({alu_src, alu_ctrl}), 32'b1_0000);
        cyc(); cyc();

        // lw with 3 wait cycles
        r0 = retire_cnt;
        d0 = dreq_cnt;
        fetchDecode(I_LW, 1'b0);
        checkOutput("lw_exec_alu", 32'({alu_src, alu_ctrl}), 32'b1_0000);
        cyc();
        for (int k = 0; k < 3; k++) begin
            checkOutput("lw_mem_wait", 32'({state, dmem_req, dmem_we, retire}), {29'd0, 3'd3} << 3 | 32'b100);
            cyc();
        end
        applyStimulus(1'b0, I_LW, 1'b0, 1'b1, 1'b0);
        checkOutput("lw_mem_ack", 32'({dmem_req, dmem_we, retire, pc_we}), 32'b1000);
        cyc();
        applyStimulus(1'b0, I_LW, 1'b0, 1'b0, 1'b0);
        checkOutput("lw_wb", 32'({state, mem_to_reg, reg_we, retire}), 32'b100_111);
        cyc();
        checkOutput("lw_fetch", 32'(state), 32'd0);
        checkOutput("lw_dmem_req_cycles", 32'(dreq_cnt - d0), 32'd4);
        checkOutput("lw_retire_once", 32'(retire_cnt - r0), 32'd1);

        fetchDecode(I_BEQ, 1'b1);
        checkOutput("beq_taken", 32'({pc_we, pc_sel, retire, alu_ctrl}), 32'b111_1000);
        cyc();
        checkOutput("beq_next_fetch", 32'({state, retire}), 32'd0);
        fetchDecode(I_BEQ, 1'b0);
        checkOutput("beq_not_taken", 32'({pc_we, pc_sel, retire}), 32'b101);
        cyc();

        fetchDecode(I_JAL, 1'b0);
        checkOutput("jal_exec_quiet", 32'({pc_we, retire, reg_we, alu_ctrl}), 32'd0);
        cyc();
        checkOutput("jal_wb", 32'({state, pc_sel, reg_we, pc_we, mem_to_reg}), 32'b100_1110);
        cyc();

        r0 = retire_cnt;
        fetchDecode(I_SW, 1'b0);
        cyc();
        applyStimulus(1'b0, I_SW, 1'b0, 1'b1, 1'b0);
        checkOutput("sw_mem_ack", 32'({dmem_req, dmem_we, pc_we, pc_sel, retire}), 32'b11101);
        cyc();
        checkOutput("sw_fetch", 32'(state), 32'd0);
        checkOutput("sw_retire_once", 32'(retire_cnt - r0), 32'd1);

        // imem timeout: 16 request cycles without ack
        applyStimulus(1'b0, I_ADD, 1'b0, 1'b0, 1'b0);
        repeat (15) cyc();
        checkOutput("imem_to_cycle16", 32'({state, fault}), 32'd0);
        cyc();
        checkOutput("imem_to_fault", 32'({state, fault, fault_cause}), 32'b101_1_01);
        checkOutput("fault_strobes_off", 32'({imem_req, dmem_req, retire, pc_we}), 32'd0);
        checkOutput("nt_no_imem_fault", 32'({nt_state, nt_fault, nt_imem_req}), 32'b000_0_1);
        cyc();
        checkOutput("fault_sticky", 32'({state, fault_cause}), 32'b101_01);
        applyStimulus(1'b1, I_ADD, 1'b0, 1'b0, 1'b0);
        cyc();
        checkOutput("fault_reset", 32'({state, fault, fault_cause}), 32'd0);

        // ack on the 16th request cycle wins
        applyStimulus(1'b0, I_ADD, 1'b0, 1'b0, 1'b0);
        repeat (15) cyc();
        applyStimulus(1'b0, I_ADD, 1'b1, 1'b0, 1'b0);
        cyc();
        applyStimulus(1'b0, I_ADD, 1'b0, 1'b0, 1'b0);
        checkOutput("imem_ack_at_threshold", 32'({state, fault}), 32'b001_0);
        cyc(); cyc(); cyc();

        // dmem timeout on a load
        fetchDecode(I_LW, 1'b0);
        cyc();
        repeat (15) cyc();
        checkOutput("dmem_to_cycle16", 32'(state), 32'd3);
        cyc();
        checkOutput("dmem_to_fault", 32'({state, fault, fault_cause}), 32'b101_1_10);
        checkOutput("nt_no_dmem_fault", 32'({nt_state, nt_fault}), 32'b011_0);
        applyStimulus(1'b1, I_ADD, 1'b0, 1'b0, 1'b0);
        cyc();

        // illegal opcode
        applyStimulus(1'b0, I_BAD, 1'b1, 1'b0, 1'b0);
        cyc();
        applyStimulus(1'b0, I_BAD, 1'b0, 1'b0, 1'b0);
        checkOutput("bad_decode", 32'(state), 32'd1);
        cyc();
        checkOutput("bad_fault", 32'({state, fault, fault_cause}), 32'b101_1_11);
        applyStimulus(1'b1, I_BAD, 1'b0, 1'b0, 1'b0);
        cyc();
        checkOutput("bad_reset", 32'({state, fault}), 32'd0);

        // reset in the middle of a store
        r0 = retire_cnt;
        fetchDecode(I_SW, 1'b0);
        cyc();
        checkOutput("sw_mem_req", 32'({state, dmem_req, dmem_we}), 32'b011_11);
        applyStimulus(1'b1, I_SW, 1'b0, 1'b0, 1'b0);
        cyc();
        checkOutput("sw_rst_state", 32'({state, dmem_req}), 32'd0);
        checkOutput("sw_rst_no_retire", 32'(retire_cnt - r0), 32'd0);
        applyStimulus(1'b0, I_ADD, 1'b0, 1'b0, 1'b0);
        checkOutput("post_release_imem_req", 32'(imem_req), 32'd1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
